// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_wb_stage                                                 |
// | Description : MEM/WB pipeline buffer plus write-back select. Drives the     |
// |               register file's low and high write ports and a forwarding    |
// |               qualifier for the hazard unit. Supports stall (hold) and     |
// |               flush (bubble).                                              |
// |               Optional macro RETIRE_CNT_EN adds a 32-bit retired-write     |
// |               counter on retire_cnt_out; otherwise the port is tied to 0.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [REG_AW-1:0] Rdst1_in,
  input  logic [DATA_W-1:0] Rdst1_val_in,
  input  logic [REG_AW-1:0] Rdst2_in,
  input  logic [DATA_W-1:0] Rdst2_val_in,
  input  logic              reglow_write_in,
  input  logic              reghigh_write_in,
  input  logic              memToReg_in,
  input  logic [DATA_W-1:0] Data_in,
  output logic              wb_low_en_out,
  output logic [REG_AW-1:0] wb_low_addr_out,
  output logic [DATA_W-1:0] wb_low_data_out,
  output logic              wb_high_en_out,
  output logic [REG_AW-1:0] wb_high_addr_out,
  output logic [DATA_W-1:0] wb_high_data_out,
  output logic              fwd_valid_out,
  output logic [31:0]       retire_cnt_out
);

  logic              r_low_en;
  logic              r_high_en;
  logic              r_mem_to_reg;
  logic [REG_AW-1:0] r_rdst1;
  logic [REG_AW-1:0] r_rdst2;
  logic [DATA_W-1:0] r_rdst1_val;
  logic [DATA_W-1:0] r_rdst2_val;
  logic [DATA_W-1:0] r_data;
  logic              w_conflict;
  logic              w_high_en;

  // Pipeline buffer: reset and flush both load an all-zero bubble, stall holds.
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      r_low_en     <= 1'b0;
      r_high_en    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rdst1      <= '0;
      r_rdst2      <= '0;
      r_rdst1_val  <= '0;
      r_rdst2_val  <= '0;
      r_data       <= '0;
    end else if (!stall_in) begin
      r_low_en     <= reglow_write_in;
      r_high_en    <= reghigh_write_in;
      r_mem_to_reg <= memToReg_in;
      r_rdst1      <= Rdst1_in;
      r_rdst2      <= Rdst2_in;
      r_rdst1_val  <= Rdst1_val_in;
      r_rdst2_val  <= Rdst2_val_in;
      r_data       <= Data_in;
    end
  end

  // When both ports target the same register the low write wins.
  assign w_conflict = r_low_en & r_high_en & (r_rdst1 == r_rdst2);
  assign w_high_en  = r_high_en & ~w_conflict;

  assign wb_low_en_out    = r_low_en;
  assign wb_low_addr_out  = r_rdst1;
  assign wb_low_data_out  = r_mem_to_reg ? r_data : r_rdst1_val;
  assign wb_high_en_out   = w_high_en;
  assign wb_high_addr_out = r_rdst2;
  assign wb_high_data_out = r_rdst2_val;
  assign fwd_valid_out    = r_low_en | w_high_en;

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count every write-carrying transaction actually accepted into the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (!flush_in && !stall_in && (reglow_write_in || reghigh_write_in)) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt_out = r_retire_cnt;
`else
  assign retire_cnt_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_wb_stage                                              |
// | Description : Self-checking bench for mem_wb_stage. A transaction-level    |
// |               model tracks the buffered write and the retire count; a     |
// |               compare process checks every output each cycle, and        |
// |               directed steps pin literal expectations.                    |
// |               Honours RETIRE_CNT_EN the same way the design does.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_wb_stage;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, stall_in, flush_in;
  logic [AW-1:0] Rdst1_in, Rdst2_in;
  logic [DW-1:0] Rdst1_val_in, Rdst2_val_in, Data_in;
  logic          reglow_write_in, reghigh_write_in, memToReg_in;
  logic          wb_low_en_out, wb_high_en_out, fwd_valid_out;
  logic [AW-1:0] wb_low_addr_out, wb_high_addr_out;
  logic [DW-1:0] wb_low_data_out, wb_high_data_out;
  logic [31:0]   retire_cnt_out;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .Rdst1_in(Rdst1_in), .Rdst1_val_in(Rdst1_val_in),
    .Rdst2_in(Rdst2_in), .Rdst2_val_in(Rdst2_val_in),
    .reglow_write_in(reglow_write_in), .reghigh_write_in(reghigh_write_in),
    .memToReg_in(memToReg_in), .Data_in(Data_in),
    .wb_low_en_out(wb_low_en_out), .wb_low_addr_out(wb_low_addr_out),
    .wb_low_data_out(wb_low_data_out), .wb_high_en_out(wb_high_en_out),
    .wb_high_addr_out(wb_high_addr_out), .wb_high_data_out(wb_high_data_out),
    .fwd_valid_out(fwd_valid_out), .retire_cnt_out(retire_cnt_out)
  );

  // One accepted MEM-stage transaction; a bubble is the all-zero transaction.
  typedef struct packed {
    logic          le;
    logic          he;
    logic          m2r;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic [DW-1:0] d;
  } txn_t;

  txn_t        m_buf = '0;
  logic [31:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the WB stage is holding after each edge.
  always @(posedge clk) begin
    if (reset) begin
      m_buf = '0;
      m_cnt = '0;
    end else if (flush_in) begin
      m_buf = '0;
    end else if (!stall_in) begin
      m_buf = '{reglow_write_in, reghigh_write_in, memToReg_in, Rdst1_in, Rdst2_in,
                Rdst1_val_in, Rdst2_val_in, Data_in};
`ifdef RETIRE_CNT_EN
      if (reglow_write_in || reghigh_write_in) m_cnt = m_cnt + 32'd1;
`endif
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (cmp_on) begin
      logic e_high;
      e_high = m_buf.he && !(m_buf.le && (m_buf.r1 == m_buf.r2));
      check("m_low_en",    32'(wb_low_en_out),    32'(m_buf.le));
      check("m_low_addr",  32'(wb_low_addr_out),  32'(m_buf.r1));
      check("m_low_data",  32'(wb_low_data_out),  32'(m_buf.m2r ? m_buf.d : m_buf.v1));
      check("m_high_en",   32'(wb_high_en_out),   32'(e_high));
      check("m_high_addr", 32'(wb_high_addr_out), 32'(m_buf.r2));
      check("m_high_data", 32'(wb_high_data_out), 32'(m_buf.v2));
      check("m_fwd",       32'(fwd_valid_out),    32'(m_buf.le | e_high));
      check("m_retire",    retire_cnt_out,        m_cnt);
    end
  end

  // Present one cycle of inputs, then return at the following falling edge.
  task automatic drive(input logic st, input logic fl,
                       input logic [AW-1:0] r1, input logic [DW-1:0] v1,
                       input logic [AW-1:0] r2, input logic [DW-1:0] v2,
                       input logic le, input logic he, input logic m2r,
                       input logic [DW-1:0] d);
    stall_in = st; flush_in = fl;
    Rdst1_in = r1; Rdst1_val_in = v1; Rdst2_in = r2; Rdst2_val_in = v2;
    reglow_write_in = le; reghigh_write_in = he; memToReg_in = m2r; Data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_low_en"},    32'(wb_low_en_out),    32'd0);
    check({tag, "_low_addr"},  32'(wb_low_addr_out),  32'd0);
    check({tag, "_low_data"},  32'(wb_low_data_out),  32'd0);
    check({tag, "_high_en"},   32'(wb_high_en_out),   32'd0);
    check({tag, "_high_data"}, 32'(wb_high_data_out), 32'd0);
    check({tag, "_fwd"},       32'(fwd_valid_out),    32'd0);
    check({tag, "_retire"},    retire_cnt_out,        32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_on = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all_zero("reset");
    reset = 1'b0;

    // ALU low write
    drive(0, 0, 3'd3, 16'h1234, 3'd1, 16'h9999, 1, 0, 0, 16'h0F0F);
    check("alu_low_en",   32'(wb_low_en_out),   32'd1);
    check("alu_low_addr", 32'(wb_low_addr_out), 32'd3);
    check("alu_low_data", 32'(wb_low_data_out), 32'h1234);
    check("alu_high_en",  32'(wb_high_en_out),  32'd0);
    check("alu_fwd",      32'(fwd_valid_out),   32'd1);

    // Load write selects memory data
    drive(0, 0, 3'd5, 16'h1111, 3'd0, 16'h0000, 1, 0, 1, 16'hBEEF);
    check("load_low_data", 32'(wb_low_data_out), 32'hBEEF);
    check("load_low_addr", 32'(wb_low_addr_out), 32'd5);

    // Dual write to the same register: low wins
    drive(0, 0, 3'd2, 16'hAAAA, 3'd2, 16'h5555, 1, 1, 0, 16'h0000);
    check("conf_low_en",   32'(wb_low_en_out),   32'd1);
    check("conf_low_data", 32'(wb_low_data_out), 32'hAAAA);
    check("conf_high_en",  32'(wb_high_en_out),  32'd0);
    check("conf_fwd",      32'(fwd_valid_out),   32'd1);

    // Dual write to distinct registers
    drive(0, 0, 3'd6, 16'h0606, 3'd7, 16'h0707, 1, 1, 0, 16'hFFFF);
    check("dual_high_en",   32'(wb_high_en_out),   32'd1);
    check("dual_high_addr", 32'(wb_high_addr_out), 32'd7);
    check("dual_high_data", 32'(wb_high_data_out), 32'h0707);

    // Write to R4, then stall three cycles with changing inputs
    drive(0, 0, 3'd4, 16'h4444, 3'd0, 16'h0000, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'(i + 1), 16'(16'h1000 + i), 3'(i + 2), 16'h2222, 1, 1, 1, 16'hDEAD);
      check("stall_low_addr", 32'(wb_low_addr_out), 32'd4);
      check("stall_low_data", 32'(wb_low_data_out), 32'h4444);
      check("stall_high_en",  32'(wb_high_en_out),  32'd0);
    end
    drive(0, 1, 3'd7, 16'h7777, 3'd6, 16'h6666, 1, 1, 0, 16'h0000);
    check("flush_low_en",  32'(wb_low_en_out),  32'd0);
    check("flush_high_en", 32'(wb_high_en_out), 32'd0);
    check("flush_fwd",     32'(fwd_valid_out),  32'd0);

    // High-only write with equal indices is not a conflict
    drive(0, 0, 3'd1, 16'h0001, 3'd1, 16'h0101, 0, 1, 0, 16'h0000);
    check("hionly_high_en", 32'(wb_high_en_out), 32'd1);
    check("hionly_fwd",     32'(fwd_valid_out),  32'd1);

    // Flush beats stall
    drive(1, 1, 3'd5, 16'h5A5A, 3'd3, 16'h3C3C, 1, 1, 0, 16'h0000);
    check("flst_low_en", 32'(wb_low_en_out), 32'd0);
    check("flst_fwd",    32'(fwd_valid_out), 32'd0);

    // Reset beats flush and stall
    drive(0, 0, 3'd3, 16'h3333, 3'd4, 16'h4444, 1, 1, 1, 16'hCAFE);
    reset = 1'b1;
    drive(1, 1, 3'd2, 16'h2222, 3'd5, 16'h5555, 1, 1, 0, 16'hBEEF);
    check_all_zero("rstpri");
    reset = 1'b0;

    // Retire counting: 5 writes, 1 non-write, 1 flushed, 2 stalled
    for (int i = 0; i < 5; i++)
      drive(0, 0, 3'(i), 16'(16'h0100 + i), 3'(i + 1), 16'h0000, 1, (i == 2), 0, 16'h0000);
    drive(0, 0, 3'd1, 16'h0000, 3'd2, 16'h0000, 0, 0, 0, 16'h0000);
    drive(0, 1, 3'd1, 16'h0001, 3'd2, 16'h0000, 1, 0, 0, 16'h0000);
    drive(1, 0, 3'd1, 16'h0001, 3'd2, 16'h0000, 1, 0, 0, 16'h0000);
    drive(1, 0, 3'd1, 16'h0001, 3'd2, 16'h0000, 0, 1, 0, 16'h0000);
`ifdef RETIRE_CNT_EN
    check("retire_five", retire_cnt_out, 32'd5);
    // Preload just below wrap, then one write rolls over to zero
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retire_cnt;
    drive(0, 0, 3'd6, 16'h0606, 3'd0, 16'h0000, 1, 0, 0, 16'h0000);
    check("retire_wrap", retire_cnt_out, 32'd0);
`else
    check("retire_tied", retire_cnt_out, 32'd0);
`endif

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline buffer plus write-back logic directly downstream of the memory stage.
- Registers the memory stage's bypassed and result signals, then selects write-back data (memory/port data vs ALU result).
- Drives the register file's two write ports (low word Rdst1, high word Rdst2), plus forwarding taps for the hazard unit.
- Supports stall (hold), flush (bubble), and an optional retired-write counter.

Parameters:
- DATA_W, 16, width of each register value and of the memory/port data word.
- REG_AW, 3, register-index width (8 general registers).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- stall_in  input  1  hold current buffer contents
- flush_in  input  1  load a bubble (all write enables 0)
- Rdst1_in  input  REG_AW  low-word destination register
- Rdst1_val_in  input  DATA_W  ALU low result
- Rdst2_in  input  REG_AW  high-word destination register
- Rdst2_val_in  input  DATA_W  ALU high result (e.g. MUL upper half)
- reglow_write_in  input  1  write enable for Rdst1
- reghigh_write_in  input  1  write enable for Rdst2
- memToReg_in  input  1  1 = low write takes Data_in, 0 = Rdst1_val_in
- Data_in  input  DATA_W  memory/port read data from the memory stage
- wb_low_en_out  output  1  register-file low write enable
- wb_low_addr_out  output  REG_AW  low write index
- wb_low_data_out  output  DATA_W  low write data
- wb_high_en_out  output  1  register-file high write enable
- wb_high_addr_out  output  REG_AW  high write index
- wb_high_data_out  output  DATA_W  high write data
- fwd_valid_out  output  1  any write pending in WB (forwarding qualifier)
- retire_cnt_out  output  32  retired-write count (feature-dependent, see below)

Behaviour:
- Latency: inputs sampled on a rising edge appear on the wb_* outputs in the same cycle after that edge (1 cycle). Outputs are a pure function of the buffer registers.
- Update priority per edge: reset > flush_in > stall_in > normal load.
  - reset: all buffer fields are 0, so all outputs are 0, including retire_cnt_out.
  - flush_in: both enables are cleared; addresses and data are cleared to 0.
  - stall_in: every field holds. Outputs stay identical, so a held write is re-presented; this is legal because register writes are idempotent.
  - normal: all *_in fields are captured.
- Write-back data:
  - wb_low_data_out = buffered memToReg ? buffered Data : buffered Rdst1_val.
  - wb_high_data_out = buffered Rdst2_val.
- Same-index conflict: if both enables are set and Rdst1 == Rdst2, wb_high_en_out is forced to 0 and the low write wins.
- fwd_valid_out = wb_low_en_out | wb_high_en_out, after conflict masking.
- The memory stage's two-cycle PC push/pop presents reglow/reghigh write = 0, so those cycles pass through as natural bubbles. No special handling is needed here.
- Reset asserted mid-stall or with flush_in: reset wins, and the state is cleared on that edge.
- The register file must use the wb_* outputs on the next edge (its write-first/read-after semantics live in the register file, not here).

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined:
  - A 32-bit counter increments by 1 on each non-stalled, non-reset edge where the value being loaded has reglow_write_in | reghigh_write_in = 1 and flush_in = 0.
  - Wraps 0xFFFFFFFF -> 0. Cleared by reset.
  - Drives retire_cnt_out.
- Not defined: no counter flops; retire_cnt_out is tied to 0.

Test Plan:
- ALU write: load Rdst1=3, Rdst1_val=0x1234, reglow_write=1, memToReg=0 -> next cycle wb_low_en=1, addr=3, data=0x1234; wb_high_en=0.
- Load write: memToReg=1, Data_in=0xBEEF, Rdst1_val=0x1111, Rdst1=5 -> wb_low_data=0xBEEF, addr=5.
- Dual write with conflict: Rdst1=Rdst2=2, both enables=1, vals 0xAAAA/0x5555 -> wb_low_en=1 with data 0xAAAA; wb_high_en=0; fwd_valid=1.
- Stall then flush: load write to R4, assert stall_in 3 cycles with changing inputs -> outputs unchanged; then flush_in -> all enables 0, fwd_valid=0.
- Reset priority: reset=1 together with flush_in=1, stall_in=1 and valid inputs -> all outputs 0 after the edge; retire_cnt_out=0.
- RETIRE_CNT_EN: 5 writing loads, 1 flushed, 2 stalled cycles -> retire_cnt_out=5. Preload near wrap (force 0xFFFFFFFF) plus one write -> 0.
